// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-way Wishbone memory arbiter.
// Requester 0 is the RX DMA, requester 1 is the TX DMA.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        ABORT = 2'd2
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic REQ_RX = 1'b0;
    localparam logic REQ_TX = 1'b1;

    // Round-robin pick: a lone requester wins, on contention the one not served last wins.
    function automatic logic pickRequester(input logic cyc0, input logic cyc1, input logic last);
        return (cyc0 && cyc1) ? ~last : ~cyc0;
    endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 bus bundle; master drives the request, slave returns the response.
interface wb_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();

    logic [AW-1:0]   adr;
    logic [DW/8-1:0] sel;
    logic            we;
    logic [DW-1:0]   wdat;
    logic            cyc;
    logic            stb;
    logic [2:0]      cti;
    logic [1:0]      bte;
    logic [DW-1:0]   rdat;
    logic            ack;
    logic            err;

    modport master (
        output adr, sel, we, wdat, cyc, stb, cti, bte,
        input  rdat, ack, err
    );

    modport slave (
        input  adr, sel, we, wdat, cyc, stb, cti, bte,
        output rdat, ack, err
    );

endinterface

// File: rtl/wb_arb_watchdog.sv
// Counts consecutive stalled strobe cycles and flags the cycle in which
// the stall reaches TIMEOUT cycles.
module wb_arb_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic wb_clk,
    input  logic wb_rst,
    input  logic run_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i && (cnt_q == LIMIT);

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin arbiter sharing the memory Wishbone port between RX DMA (r0)
// and TX DMA (r1), holding the grant for a whole cyc and aborting stalled transfers.
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 256
) (
    input  logic       wb_clk,
    input  logic       wb_rst,
    wb_if.slave        r0,
    wb_if.slave        r1,
    wb_if.master       m_wb,
    output logic [1:0] gnt_o,
    output logic       timeout_o
);

    arb_state_e state_q;
    logic [1:0] gnt_q;
    logic       last_q;
    logic       timeoutPulse_q;

    logic            inBus;
    logic            grantTx;
    logic            grantCyc;
    logic            pickTx;
    logic [AW-1:0]   selAdr;
    logic [DW-1:0]   selDat;
    logic [DW/8-1:0] selSel;
    logic            respAck;
    logic            respErr;
    logic            wdRun;
    logic            wdClr;
    logic            wdExpired;

    assign inBus    = (state_q == BUS);
    assign grantTx  = gnt_q[1];
    assign grantCyc = grantTx ? r1.cyc : r0.cyc;
    assign pickTx   = pickRequester(r0.cyc, r1.cyc, last_q);

    // Request path: only a live BUS state reaches memory; IDLE and ABORT present an idle bus.
    assign selAdr = grantTx ? r1.adr  : r0.adr;
    assign selDat = grantTx ? r1.wdat : r0.wdat;
    assign selSel = grantTx ? r1.sel  : r0.sel;

    assign m_wb.adr  = inBus ? selAdr : '0;
    assign m_wb.wdat = inBus ? selDat : '0;
    assign m_wb.sel  = inBus ? selSel : '0;
    assign m_wb.we   = inBus && (grantTx ? r1.we  : r0.we);
    assign m_wb.cyc  = inBus && grantCyc;
    assign m_wb.stb  = inBus && (grantTx ? r1.stb : r0.stb);
    assign m_wb.cti  = inBus ? (grantTx ? r1.cti : r0.cti) : CTI_CLASSIC;
    assign m_wb.bte  = inBus ? (grantTx ? r1.bte : r0.bte) : 2'b00;

    // Error wins over a simultaneous ack; late responses outside BUS are dropped.
    assign respAck = inBus && m_wb.ack && !m_wb.err;
    assign respErr = inBus && m_wb.err;

    assign r0.rdat = m_wb.rdat;
    assign r1.rdat = m_wb.rdat;
    assign r0.ack  = respAck && gnt_q[0];
    assign r1.ack  = respAck && gnt_q[1];
    assign r0.err  = (respErr || timeoutPulse_q) && gnt_q[0];
    assign r1.err  = (respErr || timeoutPulse_q) && gnt_q[1];

    assign gnt_o     = gnt_q;
    assign timeout_o = timeoutPulse_q;

    assign wdRun = inBus && m_wb.stb && !m_wb.ack && !m_wb.err;
    assign wdClr = !wdRun;

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .run_i     (wdRun),
        .clr_i     (wdClr),
        .expired_o (wdExpired)
    );

    // Owner tracking; a released owner always passes through IDLE so the bus idles one cycle.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q        <= IDLE;
            gnt_q          <= 2'b00;
            last_q         <= REQ_TX;
            timeoutPulse_q <= 1'b0;
        end else begin
            timeoutPulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (r0.cyc || r1.cyc) begin
                        state_q <= BUS;
                        gnt_q   <= pickTx ? 2'b10 : 2'b01;
                        last_q  <= pickTx;
                    end
                end
                BUS: begin
                    if (!grantCyc) begin
                        state_q <= IDLE;
                        gnt_q   <= 2'b00;
                    end else if (wdExpired) begin
                        state_q        <= ABORT;
                        timeoutPulse_q <= 1'b1;
                    end
                end
                ABORT: begin
                    if (!grantCyc) begin
                        state_q <= IDLE;
                        gnt_q   <= 2'b00;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Randomized bench for wb_mem_arbiter: two DMA agents and a flaky memory,
// checked each cycle against an ownership model built from the arbitration rules.
module tb_wb_mem_arbiter;
    import wb_arb_pkg::*;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] gnt;
    logic       tmo;

    always #5 clk = ~clk;

    wb_if #(.AW(32), .DW(32)) r0_if ();
    wb_if #(.AW(32), .DW(32)) r1_if ();
    wb_if #(.AW(32), .DW(32)) mem_if ();

    wb_mem_arbiter #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (TO)
    ) dut (
        .wb_clk    (clk),
        .wb_rst    (rst),
        .r0        (r0_if),
        .r1        (r1_if),
        .m_wb      (mem_if),
        .gnt_o     (gnt),
        .timeout_o (tmo)
    );

    int checks = 0;
    int errors = 0;

    // Requester agents
    bit          reqActive [2];
    int          beats     [2];
    int          cool      [2];
    bit          burst     [2];
    logic [31:0] reqAdr    [2];
    logic [31:0] reqDat    [2];
    logic [3:0]  reqSel    [2];
    logic        reqWe     [2];
    logic        reqCyc    [2];
    logic        reqStb    [2];
    logic [2:0]  reqCti    [2];
    logic [1:0]  reqBte    [2];

    // Memory
    logic        memAck;
    logic        memErr;
    logic [31:0] memDat;
    bit          deadMem;

    // Reference model: who owns the bus, who was served last, and how long the owner has stalled
    int owner     = -1;
    int lastOwner = 1;
    bit aborting  = 1'b0;
    bit tmoPulse  = 1'b0;
    int stall     = 0;
    bit expAck [2];
    bit expErr [2];

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit busActive();
        return (owner >= 0) && !aborting;
    endfunction

    task automatic driveIdle();
        r0_if.adr = '0; r0_if.wdat = '0; r0_if.sel = '0; r0_if.we = 1'b0;
        r0_if.cyc = 1'b0; r0_if.stb = 1'b0; r0_if.cti = '0; r0_if.bte = '0;
        r1_if.adr = '0; r1_if.wdat = '0; r1_if.sel = '0; r1_if.we = 1'b0;
        r1_if.cyc = 1'b0; r1_if.stb = 1'b0; r1_if.cti = '0; r1_if.bte = '0;
        mem_if.rdat = '0; mem_if.ack = 1'b0; mem_if.err = 1'b0;
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < 2; i++) begin
            if (!reqActive[i]) begin
                if (cool[i] > 0) begin
                    cool[i]--;
                end else if ($urandom_range(3) == 0) begin
                    reqActive[i] = 1'b1;
                    beats[i]     = $urandom_range(4, 1);
                    burst[i]     = beats[i] > 1;
                    reqWe[i]     = 1'($urandom_range(1));
                end
            end
            reqCyc[i] = reqActive[i];
            reqStb[i] = reqActive[i] && ($urandom_range(7) != 0);
            reqAdr[i] = $urandom;
            reqDat[i] = $urandom;
            reqSel[i] = 4'($urandom);
            reqBte[i] = 2'($urandom_range(3));
            reqCti[i] = !burst[i] ? CTI_CLASSIC : (beats[i] == 1 ? CTI_EOB : CTI_INCR);
        end
        r0_if.adr = reqAdr[0]; r0_if.wdat = reqDat[0]; r0_if.sel = reqSel[0]; r0_if.we = reqWe[0];
        r0_if.cyc = reqCyc[0]; r0_if.stb = reqStb[0]; r0_if.cti = reqCti[0]; r0_if.bte = reqBte[0];
        r1_if.adr = reqAdr[1]; r1_if.wdat = reqDat[1]; r1_if.sel = reqSel[1]; r1_if.we = reqWe[1];
        r1_if.cyc = reqCyc[1]; r1_if.stb = reqStb[1]; r1_if.cti = reqCti[1]; r1_if.bte = reqBte[1];

        if ($urandom_range(39) == 0) deadMem = !deadMem;
        memDat = $urandom;
        if (busActive() && reqCyc[owner] && reqStb[owner]) begin
            memAck = !deadMem && ($urandom_range(9) < 6);
            memErr = !deadMem && ($urandom_range(19) == 0);
        end else begin
            memAck = ($urandom_range(4) == 0);
            memErr = ($urandom_range(9) == 0);
        end
        mem_if.rdat = memDat;
        mem_if.ack  = memAck;
        mem_if.err  = memErr;
    endtask

    task automatic checkCycle();
        logic [1:0]  expGnt;
        logic [75:0] expBus;
        bit          ba;
        ba     = busActive();
        expGnt = (owner < 0) ? 2'b00 : (owner == 0 ? 2'b01 : 2'b10);
        expBus = '0;
        if (ba) begin
            expBus = {reqAdr[owner], reqDat[owner], reqSel[owner], reqWe[owner],
                      reqCti[owner], reqBte[owner], reqCyc[owner], reqStb[owner]};
        end
        for (int i = 0; i < 2; i++) begin
            expAck[i] = ba && (owner == i) && memAck && !memErr;
            expErr[i] = (owner == i) && ((ba && memErr) || tmoPulse);
        end
        checkOutput("gnt", gnt, expGnt);
        checkOutput("mbus", {mem_if.adr, mem_if.wdat, mem_if.sel, mem_if.we,
                             mem_if.cti, mem_if.bte, mem_if.cyc, mem_if.stb}, expBus);
        checkOutput("ack", {r1_if.ack, r0_if.ack}, {expAck[1], expAck[0]});
        checkOutput("err", {r1_if.err, r0_if.err}, {expErr[1], expErr[0]});
        checkOutput("timeout", tmo, tmoPulse);
        checkOutput("rdat", {r1_if.rdat, r0_if.rdat}, {memDat, memDat});
    endtask

    task automatic modelStep();
        bit nextPulse;
        for (int i = 0; i < 2; i++) begin
            if (expAck[i] || expErr[i]) begin
                if (tmoPulse && owner == i) beats[i] = 0;
                else beats[i]--;
                if (beats[i] <= 0) begin
                    reqActive[i] = 1'b0;
                    cool[i]      = $urandom_range(3, 1);
                end
            end
        end
        nextPulse = 1'b0;
        if (owner < 0) begin
            if (reqCyc[0] || reqCyc[1]) begin
                owner     = (reqCyc[0] && reqCyc[1]) ? 1 - lastOwner : (reqCyc[0] ? 0 : 1);
                lastOwner = owner;
                stall     = 0;
            end
        end else if (!reqCyc[owner]) begin
            owner    = -1;
            aborting = 1'b0;
            stall    = 0;
        end else if (!aborting) begin
            if (reqStb[owner] && !memAck && !memErr) begin
                stall++;
                if (stall >= TO) begin
                    aborting  = 1'b1;
                    nextPulse = 1'b1;
                    stall     = 0;
                end
            end else begin
                stall = 0;
            end
        end
        tmoPulse = nextPulse;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            reqActive[i] = 1'b0; beats[i] = 0; cool[i] = 0; burst[i] = 1'b0;
        end
        deadMem = 1'b0;
        driveIdle();
        #3;
        checkOutput("resetGnt", gnt, 2'b00);
        checkOutput("resetCyc", {mem_if.cyc, mem_if.stb}, 2'b00);
        checkOutput("resetErr", {r1_if.err, r0_if.err, r1_if.ack, r0_if.ack, tmo}, 5'b0);
        #9 rst = 1'b0;

        @(posedge clk);
        #1;
        repeat (3000) begin
            applyStimulus();
            #4;
            checkCycle();
            @(posedge clk);
            modelStep();
            #1;
        end

        // Directed: asynchronous reset mid-transfer, then round-robin restart
        driveIdle();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("releaseGnt", gnt, 2'b00);
        r0_if.cyc = 1'b1; r0_if.stb = 1'b1; r0_if.adr = 32'h100;
        @(posedge clk);
        #1;
        checkOutput("rxGrant", gnt, 2'b01);
        checkOutput("rxCyc", mem_if.cyc, 1'b1);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncRstCyc", mem_if.cyc, 1'b0);
        checkOutput("asyncRstGnt", gnt, 2'b00);
        #2 rst = 1'b0;
        r1_if.cyc = 1'b1; r1_if.stb = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("postRstContend", gnt, 2'b01);
        r0_if.cyc = 1'b0; r0_if.stb = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idleGap", {gnt, mem_if.cyc}, 3'b000);
        @(posedge clk);
        #1;
        checkOutput("txAfterRx", gnt, 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_mem_arbiter.md
# wb_mem_arbiter

Two-way Wishbone master arbiter for the Ethernet MAC memory port. It shares the single `m_wb_*` system-memory bus between the RX DMA (requester 0) and the TX DMA (requester 1). Arbitration is round-robin. A granted requester keeps the bus for its whole `cyc` cycle, including bursts. A watchdog aborts transfers that the memory never acknowledges. It sits between the MAC DMA engines and the top-level memory-side Wishbone port.

## Interface
Parameters:
- `AW`, 32: address width.
- `DW`, 32: data width; `sel` width is `DW/8`.
- `TIMEOUT`, 256: cycles an un-acked `stb` may wait before abort; legal range 2..65535.

Ports:
- `wb_clk` in 1: single clock; all logic is on the rising edge.
- `wb_rst` in 1: asynchronous, active-high reset.
- `r0_adr_i`/`r1_adr_i` in AW: requester address.
- `r0_sel_i`/`r1_sel_i` in DW/8: byte select.
- `r0_we_i`/`r1_we_i` in 1: write enable.
- `r0_dat_i`/`r1_dat_i` in DW: write data.
- `r0_cyc_i`/`r1_cyc_i` in 1: cycle request.
- `r0_stb_i`/`r1_stb_i` in 1: strobe.
- `r0_cti_i`/`r1_cti_i` in 3: cycle type.
- `r0_bte_i`/`r1_bte_i` in 2: burst type.
- `r0_dat_o`/`r1_dat_o` out DW: read data.
- `r0_ack_o`/`r1_ack_o` out 1: acknowledge.
- `r0_err_o`/`r1_err_o` out 1: error.
- `m_wb_adr_o` out AW, `m_wb_sel_o` out DW/8, `m_wb_we_o` out 1, `m_wb_dat_o` out DW, `m_wb_cyc_o` out 1, `m_wb_stb_o` out 1, `m_wb_cti_o` out 3, `m_wb_bte_o` out 2: shared memory bus.
- `m_wb_dat_i` in DW, `m_wb_ack_i` in 1, `m_wb_err_i` in 1: memory response.
- `gnt_o` out 2: one-hot current grant; `2'b00` when no requester holds the bus.
- `timeout_o` out 1: one-cycle pulse on each watchdog abort.

## Operation
- FSM states: IDLE, BUS, ABORT. Reset state is IDLE.
- Registers: `gnt` (one-hot), `last` (last served requester, reset value 1, so requester 0 wins the first contention), and the watchdog counter.
- IDLE:
  - With no `rN_cyc_i` asserted, the FSM stays in IDLE.
  - With only one requester's `cyc` asserted, that requester is granted.
  - With both asserted, the requester ≠ `last` is granted.
  - On any grant: go to BUS, load `gnt`, set `last` to the granted requester, clear the watchdog.
- BUS:
  - All `m_wb_*` outputs are a combinational mux of the granted requester's signals.
  - `m_wb_dat_i` fans out to both `rN_dat_o`.
  - `ack`/`err` route only to the granted requester; the other requester sees 0.
  - If `m_wb_ack_i` and `m_wb_err_i` are high together, `err` is forwarded and `ack` is suppressed.
  - When granted `cyc` deasserts: go to IDLE and clear `gnt`.
  - No preemption: a burst of any length (`cti` 001/010) keeps the grant until `cyc` falls.
- Watchdog:
  - Increments each cycle that `m_wb_stb_o`=1 and neither `ack` nor `err` is returned.
  - Clears on `ack`/`err` or when `stb` is low.
  - When it reaches `TIMEOUT-1` with still no response: go to ABORT.
- ABORT:
  - Force `m_wb_cyc_o`=`m_wb_stb_o`=0.
  - Assert the granted `rN_err_o` for exactly the first ABORT cycle; `timeout_o` pulses in the same cycle.
  - Stay in ABORT until the granted `cyc` drops, then go to IDLE.
  - Late memory `ack`/`err` arriving during ABORT is discarded.
- With no grant (IDLE), all `m_wb_*` outputs and all `rN_ack_o`/`rN_err_o` are 0; `rN_dat_o` still mirrors `m_wb_dat_i`.
- Reset:
  - All outputs are 0, `gnt`=0, `last`=1, FSM in IDLE.
  - Reset asserted mid-transfer drops `m_wb_cyc_o` asynchronously. The requester must restart the transfer.

## Timing
- Arbitration latency is one cycle. `cyc` sampled high at edge n gives `gnt`/`m_wb_cyc_o` high after edge n; `cyc` asserted but unsampled until edge n+1 gives `m_wb_cyc_o` high after edge n+1 (registered grant).
- Response path is combinational: zero added latency.
- After a release, IDLE lasts at least one cycle. Back-to-back owners therefore have one idle bus cycle between them.
- Abort timing: `stb` high with no response for `TIMEOUT` consecutive cycles → `rN_err_o` and `timeout_o` high in cycle `TIMEOUT+1`, counted from the first `stb` cycle.

## Structure
- Package `wb_arb_pkg`: state enum `{IDLE, BUS, ABORT}`, CTI constants (`CTI_CLASSIC`=3'b000, `CTI_INCR`=3'b010, `CTI_EOB`=3'b111), requester index constants.
- One sub-module, `wb_arb_watchdog`: a counter with `TIMEOUT` parameter, `run`/`clr` inputs and an `expired` output.
- The request mux and FSM live in the top.

## Test plan
- Single RX read at 0x100: `r0_cyc/stb`=1, memory acks one cycle later with 0xDEADBEEF → `gnt_o`=01 one cycle after request, `r0_dat_o`=0xDEADBEEF with `r0_ack_o`=1, `r1_ack_o`=0.
- Simultaneous requests out of reset → RX (`gnt_o`=01) first. After RX drops `cyc`: one idle cycle, then `gnt_o`=10. Repeat the contention → TX then RX alternate.
- TX 4-beat incrementing burst (`cti`=010,010,010,111) while RX requests → grant stays 10 for all 4 acks; RX granted only after TX `cyc` falls.
- `TIMEOUT`=8, memory never acks → `r0_err_o` and `timeout_o` pulse once in cycle 9 of `stb`, `m_wb_cyc_o`=0. A late `m_wb_ack_i` is not forwarded; IDLE follows once RX drops `cyc`.
- `m_wb_ack_i` and `m_wb_err_i` asserted together → only `rN_err_o`=1.
- `wb_rst` pulsed mid-burst → `m_wb_cyc_o` and `gnt_o` drop to 0 immediately. After reset, the first contention is won by RX.
